// File: rtl/rv32_uart.sv
// rv32_uart: memory-mapped 8N1 UART on the rv32 data bus.
// Registers (BASE_ADDR aligned to 8 bytes):
//   +0x0 DATA   write: queue byte [7:0] for transmit
//               read : {23'b0, rx_valid, rx_data}
//   +0x4 STATUS read : {26'b0, rx_frame_err, rx_overrun, tx_overflow,
//                       rx_valid, tx_full, tx_empty}
//               write: a 1 in bits 2..5 clears the matching sticky flag
// The read path is purely combinational and returns 0 when the block is not
// addressed, so the top level can OR it with the data RAM read value.
module rv32_uart #(
   parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
   parameter int          CLK_DIV    = 104,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] address_in,
   input  logic [3:0]  write_mask_in,
   input  logic [31:0] write_value_in,
   output logic [31:0] read_value_out,
   output logic        tx_out,
   input  logic        rx_in
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(CLK_DIV);

   // Bit timer reload values: a full bit period and the half-bit offset
   // used to land the RX start-bit check near its midpoint.
   localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLK_DIV / 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic sel;
   logic sel_data;
   logic sel_status;
   logic status_wr;
   logic clr_rx_valid;
   logic clr_tx_ovf;
   logic clr_rx_overrun;
   logic clr_rx_frame_err;

   assign sel        = (address_in[31:3] == BASE_ADDR[31:3]);
   assign sel_data   = sel & ~address_in[2];
   assign sel_status = sel &  address_in[2];

   // Only byte lane 0 carries meaning for either register.
   assign status_wr        = sel_status & write_mask_in[0];
   assign clr_rx_valid     = status_wr & write_value_in[2];
   assign clr_tx_ovf       = status_wr & write_value_in[3];
   assign clr_rx_overrun   = status_wr & write_value_in[4];
   assign clr_rx_frame_err = status_wr & write_value_in[5];

   // Address and lane bits this register block never looks at.
   logic unused_bus_bits;
   assign unused_bus_bits = ^{address_in[1:0], write_mask_in[3:1], write_value_in[31:8]};

   // ------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------
   logic [7:0]       fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             tx_ovf_q;

   logic fifo_full;
   logic fifo_empty;
   logic push_req;
   logic push_ok;
   logic tx_pop;

   // Fullness is judged on the count before any same-cycle pop, so a push
   // into a full FIFO is dropped even if the transmitter frees a slot.
   assign fifo_full  = (count_q == CNT_FULL);
   assign fifo_empty = (count_q == '0);
   assign push_req   = sel_data & write_mask_in[0];
   assign push_ok    = push_req & ~fifo_full;

   // Occupancy after this cycle's push and pop.
   always_comb begin
      count_d = count_q;
      if (push_ok && !tx_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_ok && tx_pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // FIFO storage: plain array without reset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (reset_n && push_ok) begin
         fifo_mem_q[wr_ptr_q] <= write_value_in[7:0];
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tx_ovf_q <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (tx_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
         if (clr_tx_ovf) begin
            tx_ovf_q <= 1'b0;
         end
         if (push_req && fifo_full) begin
            tx_ovf_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   tx_state_t        tx_state_q;
   logic [TMR_W-1:0] tx_timer_q;
   logic [2:0]       tx_bit_q;
   logic [7:0]       tx_shift_q;
   logic             tx_out_q;
   logic             tx_empty;

   // A byte leaves the FIFO when the line is idle, or on the last cycle of a
   // stop bit so consecutive frames follow each other with no idle gap.
   assign tx_pop = ~fifo_empty &
                   ((tx_state_q == TX_IDLE) ||
                    ((tx_state_q == TX_STOP) && (tx_timer_q == '0)));

   assign tx_empty = fifo_empty & (tx_state_q == TX_IDLE);
   assign tx_out   = tx_out_q;

   // TX frame sequencer with a registered line output; every state/bit
   // lasts exactly CLK_DIV cycles.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_state_q <= TX_IDLE;
         tx_timer_q <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_out_q   <= 1'b1;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (tx_pop) begin
                  tx_shift_q <= fifo_mem_q[rd_ptr_q];
                  tx_out_q   <= 1'b0;
                  tx_timer_q <= TMR_FULL;
                  tx_state_q <= TX_START;
               end
            end
            TX_START: begin
               if (tx_timer_q == '0) begin
                  tx_out_q   <= tx_shift_q[0];
                  tx_bit_q   <= '0;
                  tx_timer_q <= TMR_FULL;
                  tx_state_q <= TX_DATA;
               end else begin
                  tx_timer_q <= tx_timer_q - TMR_W'(1);
               end
            end
            TX_DATA: begin
               if (tx_timer_q == '0) begin
                  tx_timer_q <= TMR_FULL;
                  if (tx_bit_q == 3'd7) begin
                     tx_out_q   <= 1'b1;
                     tx_state_q <= TX_STOP;
                  end else begin
                     // LSB first: shift the next bit down into position 0.
                     tx_out_q   <= tx_shift_q[1];
                     tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                     tx_bit_q   <= tx_bit_q + 3'd1;
                  end
               end else begin
                  tx_timer_q <= tx_timer_q - TMR_W'(1);
               end
            end
            TX_STOP: begin
               if (tx_timer_q == '0) begin
                  if (tx_pop) begin
                     tx_shift_q <= fifo_mem_q[rd_ptr_q];
                     tx_out_q   <= 1'b0;
                     tx_timer_q <= TMR_FULL;
                     tx_state_q <= TX_START;
                  end else begin
                     tx_state_q <= TX_IDLE;
                  end
               end else begin
                  tx_timer_q <= tx_timer_q - TMR_W'(1);
               end
            end
            default: begin
               tx_out_q   <= 1'b1;
               tx_state_q <= TX_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   logic rx_meta_q;
   logic rx_sync_q;
   logic rx_prev_q;
   logic rx_fall;

   // Two-flop synchroniser for the asynchronous line, plus one more stage
   // of history for falling-edge detection; all idle high out of reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_in;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign rx_fall = rx_prev_q & ~rx_sync_q;

   rx_state_t        rx_state_q;
   logic [TMR_W-1:0] rx_timer_q;
   logic [2:0]       rx_bit_q;
   logic [7:0]       rx_shift_q;
   logic [7:0]       rx_data_q;
   logic             rx_valid_q;
   logic             rx_overrun_q;
   logic             rx_frame_err_q;

   // RX frame sequencer and its status flags; clears are applied first so a
   // same-cycle set from the frame logic wins.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_state_q     <= RX_IDLE;
         rx_timer_q     <= '0;
         rx_bit_q       <= '0;
         rx_shift_q     <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         rx_overrun_q   <= 1'b0;
         rx_frame_err_q <= 1'b0;
      end else begin
         if (clr_rx_valid) begin
            rx_valid_q <= 1'b0;
         end
         if (clr_rx_overrun) begin
            rx_overrun_q <= 1'b0;
         end
         if (clr_rx_frame_err) begin
            rx_frame_err_q <= 1'b0;
         end

         case (rx_state_q)
            RX_IDLE: begin
               if (rx_fall) begin
                  rx_timer_q <= TMR_HALF;
                  rx_state_q <= RX_START;
               end
            end
            RX_START: begin
               if (rx_timer_q == '0) begin
                  // A start bit that is already high again was a glitch.
                  if (!rx_sync_q) begin
                     rx_bit_q   <= '0;
                     rx_timer_q <= TMR_FULL;
                     rx_state_q <= RX_DATA;
                  end else begin
                     rx_state_q <= RX_IDLE;
                  end
               end else begin
                  rx_timer_q <= rx_timer_q - TMR_W'(1);
               end
            end
            RX_DATA: begin
               if (rx_timer_q == '0) begin
                  rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                  rx_timer_q <= TMR_FULL;
                  if (rx_bit_q == 3'd7) begin
                     rx_state_q <= RX_STOP;
                  end else begin
                     rx_bit_q <= rx_bit_q + 3'd1;
                  end
               end else begin
                  rx_timer_q <= rx_timer_q - TMR_W'(1);
               end
            end
            RX_STOP: begin
               if (rx_timer_q == '0) begin
                  if (rx_sync_q) begin
                     rx_data_q  <= rx_shift_q;
                     rx_valid_q <= 1'b1;
                     if (rx_valid_q) begin
                        rx_overrun_q <= 1'b1;
                     end
                  end else begin
                     rx_frame_err_q <= 1'b1;
                  end
                  rx_state_q <= RX_IDLE;
               end else begin
                  rx_timer_q <= rx_timer_q - TMR_W'(1);
               end
            end
            default: begin
               rx_state_q <= RX_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------

   // Combinational register read, zero when the block is not addressed.
   always_comb begin
      read_value_out = '0;
      if (sel_data) begin
         read_value_out = {23'b0, rx_valid_q, rx_data_q};
      end else if (sel_status) begin
         read_value_out = {26'b0, rx_frame_err_q, rx_overrun_q, tx_ovf_q,
                           rx_valid_q, fifo_full, tx_empty};
      end
   end

endmodule

// File: tb/tb_rv32_uart.sv
// Directed bench for rv32_uart: reset state, single and back-to-back
// transmit with FIFO overflow, receive with overrun and framing error,
// glitch rejection, and a reset in the middle of a transmit frame.
module tb_rv32_uart;

   localparam logic [31:0] BASE   = 32'h0001_0000;
   localparam logic [31:0] A_DATA = BASE;
   localparam logic [31:0] A_STAT = BASE + 32'h4;
   localparam logic [31:0] A_NONE = BASE + 32'h8;
   localparam int          DIV    = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] address_in = '0;
   logic [3:0]  write_mask_in = '0;
   logic [31:0] write_value_in = '0;
   logic [31:0] read_value_out;
   logic        tx_out;
   logic        rx_in = 1'b1;

   int checks = 0;
   int errors = 0;

   // Bytes decoded from tx_out: {stop_bit, data}.
   logic [8:0] tx_bytes[$];

   rv32_uart #(
      .BASE_ADDR (BASE),
      .CLK_DIV   (DIV),
      .FIFO_DEPTH(8)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .address_in    (address_in),
      .write_mask_in (write_mask_in),
      .write_value_in(write_value_in),
      .read_value_out(read_value_out),
      .tx_out        (tx_out),
      .rx_in         (rx_in)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %-14s got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %-14s 0x%08h", tag, got);
      end
   endtask

   // Call at a negedge; the following posedge samples the write.
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask);
      address_in     = addr;
      write_value_in = data;
      write_mask_in  = mask;
      @(negedge clk);
      write_mask_in  = 4'b0000;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      write_mask_in = 4'b0000;
      address_in    = addr;
      #1;
      data = read_value_out;
   endtask

   // Drive one 8N1 frame on rx_in, then leave the line idle for a while.
   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_in = f[i];
         repeat (DIV) @(negedge clk);
      end
      rx_in = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Line monitor: sample each bit at its midpoint and queue the byte.
   initial begin : tx_monitor
      logic [7:0] b;
      logic       stop;
      forever begin
         @(negedge clk);
         if (tx_out === 1'b0) begin
            repeat (DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = tx_out;
            end
            repeat (DIV) @(negedge clk);
            stop = tx_out;
            tx_bytes.push_back({stop, b});
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] rd;
      logic [9:0]  frame;
      logic        done;

      // Reset held for two edges.
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      check("rst_tx", 32'(tx_out), 32'h1);
      bus_read(A_STAT, rd);
      check("rst_status", rd, 32'h1);
      bus_read(A_DATA, rd);
      check("rst_data", rd, 32'h0);

      // Single byte; upper lanes carry junk that must be ignored.
      @(negedge clk);
      bus_write(A_DATA, 32'h1234_56A5, 4'b1111);
      check("tx_pre_start", 32'(tx_out), 32'h1);
      frame = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 10 * DIV; i++) begin
         @(negedge clk);
         check($sformatf("tx_a5_b%0d_c%0d", i / DIV, i % DIV), 32'(tx_out), 32'(frame[i / DIV]));
      end
      @(negedge clk);
      bus_read(A_STAT, rd);
      check("tx_done_stat", rd, 32'h1);
      check("tx_mon_count", 32'(tx_bytes.size()), 32'd1);
      check("tx_mon_byte", (tx_bytes.size() > 0) ? 32'(tx_bytes[0]) : 32'h0, 32'h1A5);
      tx_bytes.delete();

      // Ten writes on consecutive edges into an 8-deep FIFO.
      for (int i = 0; i < 10; i++) begin
         bus_write(A_DATA, 32'h10 + 32'(i), 4'b0001);
      end
      bus_read(A_STAT, rd);
      check("ovf_stat", rd, 32'h0A);
      done = 1'b0;
      for (int c = 0; c < 800 && !done; c++) begin
         @(negedge clk);
         bus_read(A_STAT, rd);
         if (tx_bytes.size() >= 9 && rd[0]) done = 1'b1;
      end
      check("ovf_drained", 32'(done), 32'h1);
      check("ovf_count", 32'(tx_bytes.size()), 32'd9);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("ovf_byte%0d", i),
               (i < tx_bytes.size()) ? 32'(tx_bytes[i]) : 32'h0,
               32'h110 + 32'(i));
      end
      bus_read(A_STAT, rd);
      check("ovf_sticky", rd, 32'h09);
      @(negedge clk);
      bus_write(A_STAT, 32'h8, 4'b0001);
      bus_read(A_STAT, rd);
      check("ovf_cleared", rd, 32'h01);
      tx_bytes.delete();

      // Receive two good frames without clearing in between.
      @(negedge clk);
      send_rx(8'h3C, 1'b1);
      bus_read(A_DATA, rd);
      check("rx_data1", rd, 32'h13C);
      bus_read(A_STAT, rd);
      check("rx_stat1", rd, 32'h05);
      @(negedge clk);
      send_rx(8'h55, 1'b1);
      bus_read(A_DATA, rd);
      check("rx_data2", rd, 32'h155);
      bus_read(A_STAT, rd);
      check("rx_stat2", rd, 32'h15);
      bus_read(A_NONE, rd);
      check("unselected", rd, 32'h0);
      @(negedge clk);
      bus_write(A_STAT, 32'h3C, 4'b0001);
      bus_read(A_STAT, rd);
      check("rx_cleared", rd, 32'h01);
      bus_read(A_DATA, rd);
      check("rx_data_kept", rd, 32'h055);

      // Frame with a low stop bit is discarded and flagged.
      @(negedge clk);
      send_rx(8'h7E, 1'b0);
      bus_read(A_STAT, rd);
      check("frm_stat", rd, 32'h21);
      bus_read(A_DATA, rd);
      check("frm_data", rd, 32'h055);
      @(negedge clk);
      bus_write(A_STAT, 32'h20, 4'b0001);
      bus_read(A_STAT, rd);
      check("frm_cleared", rd, 32'h01);

      // One-cycle low glitch on the idle line.
      @(negedge clk);
      rx_in = 1'b0;
      @(negedge clk);
      rx_in = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      bus_read(A_STAT, rd);
      check("glitch_stat", rd, 32'h01);
      bus_read(A_DATA, rd);
      check("glitch_data", rd, 32'h055);

      // Reset during data bit 3 of 0xA5 with a second byte still queued.
      @(negedge clk);
      bus_write(A_DATA, 32'hA5, 4'b0001);
      bus_write(A_DATA, 32'h0F, 4'b0001);
      repeat (17) @(negedge clk);
      check("mid_bit3_low", 32'(tx_out), 32'h0);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_tx", 32'(tx_out), 32'h1);
      reset_n = 1'b1;
      bus_read(A_STAT, rd);
      check("mid_rst_stat", rd, 32'h01);
      bus_read(A_DATA, rd);
      check("mid_rst_data", rd, 32'h0);
      repeat (2 * DIV) @(negedge clk);
      check("post_rst_tx", 32'(tx_out), 32'h1);
      bus_read(A_STAT, rd);
      check("post_rst_stat", rd, 32'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
